// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_e;

    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_LEN_DEF    = 3;

    // Largest count a w-bit counter can hold; reaching it without an edge is a timeout
    function automatic int unsigned cnt_sat(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_in_cond.sv
// Input conditioning for pwm_capture: synchronizer, optional deglitch filter,
// and edge detection against a registered copy of the conditioned level.
// Optional filter enabled by defining PWM_CAP_FILTER_EN.
module pwm_in_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pwm,
    output logic o_rise,
    output logic o_fall
);

    // Illegal configurations leave a marker scope in the hierarchy
    if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_params
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   lvl;
    logic                   s_d1_q;

    // Metastability synchronizer on the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], i_pwm};
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAP_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);

    logic            filt_q;
    logic [FC_W-1:0] run_q;

    // Deglitch: accept a new level only after FILT_LEN consecutive differing samples.
    // The delay is the same for both polarities, so measured widths are preserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
            run_q  <= '0;
        end else if (s != filt_q) begin
            if (run_q == FC_W'(FILT_LEN - 1)) begin
                filt_q <= s;
                run_q  <= '0;
            end else begin
                run_q <= run_q + FC_W'(1);
            end
        end else begin
            run_q <= '0;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = s;
`endif

    // Previous conditioned level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s_d1_q <= 1'b0;
        else     s_d1_q <= lvl;
    end

    assign o_rise = lvl & ~s_d1_q;
    assign o_fall = ~lvl & s_d1_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period (rising edge to rising edge) of
// an asynchronous PWM input in clk cycles, one registered result per period.
// Optional input deglitch filter enabled by defining PWM_CAP_FILTER_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_pwm,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic [CNT_W-1:0] o_period_cnt,
    output logic             o_valid,
    output logic             o_timeout,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(cnt_sat(CNT_W));

    logic rise, fall, sat;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             valid_q, valid_d;
    logic             tmo_q, tmo_d;

    pwm_in_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_in_cond (
        .clk    (clk),
        .rst    (rst),
        .i_pwm  (i_pwm),
        .o_rise (rise),
        .o_fall (fall)
    );

    assign sat     = (cnt_q == SAT);
    // Hold at saturation so a fall taken on the last count still times out in S_LOW
    assign cnt_inc = sat ? SAT : cnt_q + CNT_W'(1);

    // State, counters and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_lat_q <= '0;
            high_q   <= '0;
            per_q    <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_lat_q <= hi_lat_d;
            high_q   <= high_d;
            per_q    <= per_d;
            valid_q  <= valid_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next state: edges take priority over saturation
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (rise) state_d = S_HIGH;
            S_HIGH: if (fall) state_d = S_LOW;
                    else if (sat) state_d = S_IDLE;
            S_LOW:  if (rise) state_d = S_HIGH;
                    else if (sat) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Counter, latches and result updates for the current state
    always_comb begin
        cnt_d    = cnt_q;
        hi_lat_d = hi_lat_q;
        high_d   = high_q;
        per_d    = per_q;
        valid_d  = 1'b0;
        tmo_d    = tmo_q;
        unique case (state_q)
            S_IDLE: cnt_d = rise ? CNT_W'(1) : '0;
            S_HIGH: begin
                if (fall) begin
                    hi_lat_d = cnt_q;
                    cnt_d    = cnt_inc;
                end else if (sat) begin
                    tmo_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_LOW: begin
                if (rise) begin
                    per_d   = cnt_q;
                    high_d  = hi_lat_q;
                    valid_d = 1'b1;
                    tmo_d   = 1'b0;
                    cnt_d   = CNT_W'(1);
                end else if (sat) begin
                    tmo_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign o_high_cnt   = high_q;
    assign o_period_cnt = per_q;
    assign o_valid      = valid_q;
    assign o_timeout    = tmo_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture. The waveform is built from segments;
// the reference model derives expected results from the times of the input
// edges alone (period = rise-to-rise, high = rise-to-fall, dropped if the
// period exceeds the counter range).
module tb_pwm_capture;

    localparam int CNT_W       = 10;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 3;
    localparam int SAT         = (1 << CNT_W) - 1;
`ifdef PWM_CAP_FILTER_EN
    localparam int MINW = FILT_LEN;
`else
    localparam int MINW = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_pwm = 1'b0;
    logic [CNT_W-1:0] o_high_cnt, o_period_cnt;
    logic             o_valid, o_timeout, o_busy;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_pwm        (i_pwm),
        .o_high_cnt   (o_high_cnt),
        .o_period_cnt (o_period_cnt),
        .o_valid      (o_valid),
        .o_timeout    (o_timeout),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { int hi; int per; } res_t;
    res_t exp_q[$];
    int   last_rise = -1;
    int   last_fall = -1;

    // Drive one level for n cycles; input edges feed the reference model
    task automatic seg(input logic lvl, input int n);
        if (lvl && !i_pwm) begin
            if (last_rise >= 0 && (cyc - last_rise) <= SAT)
                exp_q.push_back('{last_fall - last_rise, cyc - last_rise});
            last_rise = cyc;
        end else if (!lvl && i_pwm) begin
            last_fall = cyc;
        end
        i_pwm = lvl;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Scoreboard: every valid strobe must match the next expected period
    always @(negedge clk) begin
        res_t r;
        if (!rst && o_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL valid_unexpected: got high=%0d period=%0d, expected no result",
                         o_high_cnt, o_period_cnt);
            end else begin
                r = exp_q.pop_front();
                if (int'(o_high_cnt) !== r.hi || int'(o_period_cnt) !== r.per || o_timeout !== 1'b0) begin
                    n_err++;
                    $display("FAIL result: got high=%0d period=%0d timeout=%0b, expected high=%0d period=%0d timeout=0",
                             o_high_cnt, o_period_cnt, o_timeout, r.hi, r.per);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if (o_high_cnt !== '0 || o_period_cnt !== '0 || o_valid !== 1'b0 ||
            o_timeout !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: got high=%0d period=%0d valid=%0b timeout=%0b busy=%0b, expected all 0",
                     o_high_cnt, o_period_cnt, o_valid, o_timeout, o_busy);
        end
        rst = 1'b0;
        seg(1'b0, 10);
        n_cmp++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%0b valid=%0b, expected 0/0", o_busy, o_valid);
        end
    endtask

    task automatic test_duty64();
        seg(1'b0, 20);
        for (int i = 0; i < 5; i++) begin seg(1'b1, 64); seg(1'b0, 192); end
        seg(1'b1, 8);
        n_cmp++;
        if (o_high_cnt !== 10'd64 || o_period_cnt !== 10'd256 || o_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL duty64: got high=%0d period=%0d timeout=%0b, expected 64/256/0",
                     o_high_cnt, o_period_cnt, o_timeout);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL duty64_drain: got %0d outstanding results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_extreme_duty();
        seg(1'b0, 20);
        for (int i = 0; i < 4; i++) begin seg(1'b1, MINW); seg(1'b0, 256 - MINW); end
        seg(1'b1, 8);
        n_cmp++;
        if (int'(o_high_cnt) !== MINW || o_period_cnt !== 10'd256) begin
            n_err++;
            $display("FAIL duty_min: got high=%0d period=%0d, expected %0d/256",
                     o_high_cnt, o_period_cnt, MINW);
        end
        for (int i = 0; i < 4; i++) begin seg(1'b1, 256 - MINW); seg(1'b0, MINW); end
        seg(1'b1, 8);
        n_cmp++;
        if (int'(o_high_cnt) !== 256 - MINW || o_period_cnt !== 10'd256) begin
            n_err++;
            $display("FAIL duty_max: got high=%0d period=%0d, expected %0d/256",
                     o_high_cnt, o_period_cnt, 256 - MINW);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL extreme_drain: got %0d outstanding results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_stuck_low();
        seg(1'b0, 20);
        seg(1'b1, 64); seg(1'b0, 192);
        seg(1'b1, 64);
        // 1025 cycles after the last rise, counting still in progress
        seg(1'b0, 1025 - 64);
        n_cmp++;
        if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL stuck_low_pre: got timeout=%0b busy=%0b, expected 0/1", o_timeout, o_busy);
        end
        seg(1'b0, 1);
        n_cmp++;
        if (o_timeout !== 1'b1 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL stuck_low_edge: got timeout=%0b busy=%0b, expected 1/0", o_timeout, o_busy);
        end
        seg(1'b0, 500);
        n_cmp++;
        if (o_timeout !== 1'b1 || o_busy !== 1'b0 || o_high_cnt !== 10'd64 || o_period_cnt !== 10'd256) begin
            n_err++;
            $display("FAIL stuck_low_hold: got timeout=%0b busy=%0b high=%0d period=%0d, expected 1/0/64/256",
                     o_timeout, o_busy, o_high_cnt, o_period_cnt);
        end
        for (int i = 0; i < 3; i++) begin seg(1'b1, 128); seg(1'b0, 128); end
        seg(1'b1, 8);
        n_cmp++;
        if (o_timeout !== 1'b0 || o_high_cnt !== 10'd128 || o_period_cnt !== 10'd256) begin
            n_err++;
            $display("FAIL stuck_low_recover: got timeout=%0b high=%0d period=%0d, expected 0/128/256",
                     o_timeout, o_high_cnt, o_period_cnt);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL stuck_low_drain: got %0d outstanding results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_saturation();
        seg(1'b0, 20);
        seg(1'b1, 100); seg(1'b0, 923);
        seg(1'b1, 100);
        n_cmp++;
        if (o_period_cnt !== 10'd1023 || o_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL sat_edge_wins: got period=%0d timeout=%0b, expected 1023/0", o_period_cnt, o_timeout);
        end
        seg(1'b0, 924);
        seg(1'b1, 20);
        n_cmp++;
        if (o_timeout !== 1'b1 || o_busy !== 1'b1 || o_period_cnt !== 10'd1023) begin
            n_err++;
            $display("FAIL sat_overrun: got timeout=%0b busy=%0b period=%0d, expected 1/1/1023",
                     o_timeout, o_busy, o_period_cnt);
        end
        seg(1'b0, 50);
        seg(1'b1, 8);
        n_cmp++;
        if (o_timeout !== 1'b0 || o_high_cnt !== 10'd20 || o_period_cnt !== 10'd70) begin
            n_err++;
            $display("FAIL sat_recover: got timeout=%0b high=%0d period=%0d, expected 0/20/70",
                     o_timeout, o_high_cnt, o_period_cnt);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sat_drain: got %0d outstanding results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_duty_switch();
        seg(1'b0, 20);
        for (int i = 0; i < 2; i++) begin seg(1'b1, 64); seg(1'b0, 192); end
        for (int i = 0; i < 2; i++) begin seg(1'b1, 192); seg(1'b0, 64); end
        seg(1'b1, 8);
        n_cmp++;
        if (o_high_cnt !== 10'd192 || o_period_cnt !== 10'd256) begin
            n_err++;
            $display("FAIL switch_boundary: got high=%0d period=%0d, expected 192/256", o_high_cnt, o_period_cnt);
        end
        seg(1'b1, 56); seg(1'b0, 100);
        seg(1'b1, 192); seg(1'b0, 64);
        seg(1'b1, 8);
        n_cmp++;
        if (o_high_cnt !== 10'd192 || o_period_cnt !== 10'd256) begin
            n_err++;
            $display("FAIL switch_mid: got high=%0d period=%0d, expected 192/256", o_high_cnt, o_period_cnt);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL switch_drain: got %0d outstanding results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        seg(1'b0, 20);
        seg(1'b1, 64); seg(1'b0, 192);
        seg(1'b1, 64); seg(1'b0, 100);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (o_high_cnt !== '0 || o_period_cnt !== '0 || o_valid !== 1'b0 ||
            o_timeout !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got high=%0d period=%0d valid=%0b timeout=%0b busy=%0b, expected all 0",
                     o_high_cnt, o_period_cnt, o_valid, o_timeout, o_busy);
        end
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        last_rise = -1;
        seg(1'b0, 50);
        seg(1'b1, 64); seg(1'b0, 192);
        n_cmp++;
        if (o_high_cnt !== '0 || o_period_cnt !== '0 || o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_period: got high=%0d period=%0d busy=%0b, expected 0/0/1",
                     o_high_cnt, o_period_cnt, o_busy);
        end
        seg(1'b1, 8);
        n_cmp++;
        if (o_high_cnt !== 10'd64 || o_period_cnt !== 10'd256) begin
            n_err++;
            $display("FAIL reset_resume: got high=%0d period=%0d, expected 64/256", o_high_cnt, o_period_cnt);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_drain: got %0d outstanding results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_random();
        int h, l;
        seg(1'b0, 20);
        for (int i = 0; i < 30; i++) begin
            h = int'($urandom_range(400, MINW));
            l = int'($urandom_range(400, MINW));
            seg(1'b1, h);
            seg(1'b0, l);
        end
        seg(1'b1, 8);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL random_drain: got %0d outstanding results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

`ifdef PWM_CAP_FILTER_EN
    task automatic test_glitch();
        seg(1'b0, 20);
        seg(1'b1, 64); seg(1'b0, 192);
        // Two-cycle low glitch inside the high phase, invisible to the model
        seg(1'b1, 30);
        i_pwm = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        i_pwm = 1'b1;
        repeat (32) begin @(posedge clk); #1; end
        seg(1'b0, 192);
        seg(1'b1, 8);
        n_cmp++;
        if (o_high_cnt !== 10'd64 || o_period_cnt !== 10'd256) begin
            n_err++;
            $display("FAIL glitch_short: got high=%0d period=%0d, expected 64/256", o_high_cnt, o_period_cnt);
        end
        // Three-cycle glitch is a real pulse
        seg(1'b1, 22); seg(1'b0, 3); seg(1'b1, 31); seg(1'b0, 192);
        seg(1'b1, 8);
        n_cmp++;
        if (o_high_cnt !== 10'd31 || o_period_cnt !== 10'd223) begin
            n_err++;
            $display("FAIL glitch_long: got high=%0d period=%0d, expected 31/223", o_high_cnt, o_period_cnt);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL glitch_drain: got %0d outstanding results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_duty64();
        test_extreme_duty();
        test_stuck_low();
        test_saturation();
        test_duty_switch();
        test_reset_mid();
        test_random();
`ifdef PWM_CAP_FILTER_EN
        test_glitch();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
